// File: rtl/regfile_pkg.sv
// Shared register-file types: default widths, write-arbiter state and the write-port record.
package regfile_pkg;

    localparam int unsigned RF_AW = 5;
    localparam int unsigned RF_DW = 32;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant with a tie-break register. REGFILE_ARB_RR_EN selects round-robin ties;
// without it, req[0] always wins ties and no state is kept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import regfile_pkg::*;

`ifdef REGFILE_ARB_RR_EN
    arb_state_e state_q, state_d;

    always_comb begin
        gnt     = req;
        state_d = state_q;
        if (req == 2'b11) begin
            gnt = (state_q == PRI0) ? 2'b01 : 2'b10;
        end
        // Hand the tie-break to whoever lost this grant.
        if (gnt[0]) begin
            state_d = PRI1;
        end else if (gnt[1]) begin
            state_d = PRI0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI0;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_clk_rst;

    assign gnt            = {req[1] & ~req[0], req[0]};
    assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between execute (req0) and load (req1) writeback.
// Tie-break policy is round-robin when REGFILE_ARB_RR_EN is defined, else fixed req0 priority.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned DW   = RF_DW,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic            pend_valid,
    output logic [CNTW-1:0] conflict_cnt
);

    logic [1:0]      gnt;
    rf_wr_t          wr_q, wr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Address/data hold when nothing is written; writes to r0 complete but never reach the file.
    always_comb begin
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        if (gnt[0] && (req0_addr != '0)) begin
            wr_d = '{we: 1'b1, addr: req0_addr, data: req0_data};
        end else if (gnt[1] && (req1_addr != '0)) begin
            wr_d = '{we: 1'b1, addr: req1_addr, data: req1_data};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign rf_we        = wr_q.we;
    assign rf_wa        = wr_q.addr;
    assign rf_wd        = wr_q.data;
    assign pend_valid   = wr_q.we;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised scoreboard bench for regfile_wr_arbiter; honours REGFILE_ARB_RR_EN like the RTL.
module tb_regfile_wr_arbiter;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CNTW = 16;
    localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0]   req0_addr, req1_addr, rf_wa;
    logic [DW-1:0]   req0_data, req1_data, rf_wd;
    logic            rf_we, pend_valid;
    logic [CNTW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .pend_valid   (pend_valid),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    bit            p_valid[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_data[2];
    int            favour = 0;   // requester that wins a tie in the model
    longint        cnt_m = 0;
    int            last_gnt = -1;
    int            exp_seq[4];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each registered write must match the oldest expected write from the prior cycle.
    always @(posedge clk) begin
        exp_t e;
        #3;
        if (rst_n) begin
            chk("pend_valid_eq_we", longint'(pend_valid), longint'(rf_we));
            if (rf_we) begin
                if (sb.size() == 0) begin
                    chk("spurious_write", longint'(rf_we), 0);
                end else begin
                    e = sb.pop_front();
                    chk("write_latency", longint'(cyc - 1), longint'(e.cyc));
                    chk("rf_wa", longint'(rf_wa), longint'(e.addr));
                    chk("rf_wd", longint'(rf_wd), longint'(e.data));
                end
            end else if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
                chk("missing_write", longint'(rf_we), 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic apply();
        req0_valid = p_valid[0];
        req0_addr  = p_addr[0];
        req0_data  = p_data[0];
        req1_valid = p_valid[1];
        req1_addr  = p_addr[1];
        req1_data  = p_data[1];
    endtask

    // One clock: drive pending requests, check grants against the model, then advance.
    task automatic step();
        int g;
        bit both;
        apply();
        @(negedge clk);
        both = p_valid[0] && p_valid[1];
        g = -1;
        if (both) g = favour;
        else if (p_valid[0]) g = 0;
        else if (p_valid[1]) g = 1;
        chk("req0_ready", longint'(req0_ready), longint'(g == 0));
        chk("req1_ready", longint'(req1_ready), longint'(g == 1));
        chk("conflict_cnt", longint'(conflict_cnt), cnt_m);
        last_gnt = req0_ready ? 0 : (req1_ready ? 1 : -1);
        if (both && cnt_m < CNT_MAX) cnt_m++;
        if (g >= 0) begin
            if (p_addr[g] != '0) sb.push_back('{cyc, p_addr[g], p_data[g]});
            p_valid[g] = 1'b0;
`ifdef REGFILE_ARB_RR_EN
            favour = 1 - g;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        apply();
        sb.delete();
        favour = 0;
        cnt_m  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef REGFILE_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        rst_n = 1'b0;
        p_valid[0] = 1'b1; p_addr[0] = 5'd5; p_data[0] = 32'hDEAD_BEEF;
        p_valid[1] = 1'b0; p_addr[1] = '0;   p_data[1] = '0;
        apply();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rf_we", longint'(rf_we), 0);
        chk("reset_rf_wa", longint'(rf_wa), 0);
        chk("reset_rf_wd", longint'(rf_wd), 0);
        chk("reset_pend_valid", longint'(pend_valid), 0);
        chk("reset_conflict_cnt", longint'(conflict_cnt), 0);
        rst_n = 1'b1;

        // Single req0 write: grant in N, write visible in N+1 only.
        step();
        chk("first_grant_req0", last_gnt, 0);
        chk("single_we", longint'(rf_we), 1);
        chk("single_wa", longint'(rf_wa), 5);
        chk("single_wd", longint'(rf_wd), 64'hDEAD_BEEF);
        step();
        chk("single_we_off", longint'(rf_we), 0);

        // Sustained tie from a fresh reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p_valid[0] = 1'b1; p_addr[0] = 5'd3; p_data[0] = $urandom;
            p_valid[1] = 1'b1; p_addr[1] = 5'd7; p_data[1] = $urandom;
            step();
            chk("tie_grant", last_gnt, exp_seq[i]);
            chk("tie_wa", longint'(rf_wa), (exp_seq[i] == 1) ? 7 : 3);
        end
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        step();
        chk("tie_conflict_cnt", longint'(conflict_cnt), 4);

        // Write to r0 completes the handshake but never reaches the file.
        p_valid[1] = 1'b1; p_addr[1] = '0; p_data[1] = 32'h1234;
        step();
        chk("r0_grant_req1", last_gnt, 1);
        chk("r0_dropped_we", longint'(rf_we), 0);

        // Random traffic with held requests.
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_valid[r] && $urandom_range(0, 99) < 40) begin
                    p_valid[r] = 1'b1;
                    p_addr[r]  = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(0, 31));
                    p_data[r]  = $urandom;
                end
            end
            step();
        end
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        step();
        step();

        // Reset while a write is staged: output clears without a clock edge.
        p_valid[0] = 1'b1; p_addr[0] = 5'd9; p_data[0] = 32'hCAFE_0009;
        step();
        chk("staged_we", longint'(rf_we), 1);
        rst_n = 1'b0;
        p_valid[0] = 1'b0;
        apply();
        sb.delete();
        favour = 0;
        cnt_m  = 0;
        #1;
        chk("async_clear_we", longint'(rf_we), 0);
        chk("async_clear_pend", longint'(pend_valid), 0);
        chk("async_clear_wa", longint'(rf_wa), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p_valid[0] = 1'b1; p_addr[0] = 5'd11; p_data[0] = $urandom;
        p_valid[1] = 1'b1; p_addr[1] = 5'd12; p_data[1] = $urandom;
        step();
        chk("post_reset_grant", last_gnt, 0);
        step();

        // Counter saturation.
        for (int n = 0; n < (1 << CNTW) + 3; n++) begin
            p_valid[0] = 1'b1; p_addr[0] = 5'd1; p_data[0] = n;
            p_valid[1] = 1'b1; p_addr[1] = 5'd2; p_data[1] = ~n;
            step();
        end
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        step();
        chk("cnt_saturated", longint'(conflict_cnt), 64'hFFFF);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
